// File: rtl/cs_seq.sv
// Command-path sequencer: UDP start -> MAC-to-FIFO-C -> FIFO-C-to-CS -> done,
// with FIFO-full gating, per-stage watchdog, and command/error counters.
module cs_seq #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifoa_full,
   input  logic             fifoc_full,
   input  logic             fifod_full,
   input  logic             fs_udp_rx,
   output logic             fd_udp_rx,
   output logic             fs_mac2fifoc,
   input  logic             fd_mac2fifoc,
   output logic             fs_fifoc2cs,
   input  logic             fd_fifoc2cs,
   output logic             busy,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cmd_cnt,
   output logic [7:0]       err_cnt
);

   // Handshake: each fs output is a level held for the whole stage; the stage
   // exits on the first cycle its fd input is sampled high, and fs drops on
   // that same edge. fd is not required to fall before the next stage starts.

   localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_MAC  = 3'd2,
      S_FIFO = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_fifoa_q;
   logic             w_full;
   logic             w_tmo_hit;
   logic             w_cmd_inc;
   logic             w_ovf_edge;
   logic             w_watched;
   logic [8:0]       w_err_sum;

   assign w_full     = fifoc_full | fifod_full;
   assign w_tmo_hit  = (TIMEOUT != 0) && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
   assign w_ovf_edge = fifoa_full & ~r_fifoa_q;
   assign w_watched  = (r_state == S_WAIT) || (r_state == S_MAC) ||
                       (r_state == S_FIFO) || (r_state == S_DONE);
   assign w_err_sum  = {1'b0, err_cnt} + 9'(w_ovf_edge) + 9'(r_state == S_ERR);
   assign state      = r_state;

   // Exit conditions are tested before the watchdog so a same-cycle exit wins.
   always_comb begin
      w_next    = r_state;
      w_cmd_inc = 1'b0;
      case (r_state)
         S_IDLE: if (fs_udp_rx) w_next = w_full ? S_WAIT : S_MAC;
         S_WAIT: begin
            if (!w_full)        w_next = S_MAC;
            else if (w_tmo_hit) w_next = S_ERR;
         end
         S_MAC: begin
            if (fd_mac2fifoc)   w_next = S_FIFO;
            else if (w_tmo_hit) w_next = S_ERR;
         end
         S_FIFO: begin
            if (fd_fifoc2cs) begin
               w_next    = S_DONE;
               w_cmd_inc = 1'b1;
            end else if (w_tmo_hit) begin
               w_next = S_ERR;
            end
         end
         S_DONE: begin
            if (!fs_udp_rx)     w_next = S_IDLE;
            else if (w_tmo_hit) w_next = S_ERR;
         end
         S_ERR:   w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered (Moore).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_tmo_cnt    <= '0;
         r_fifoa_q    <= 1'b0;
         fs_mac2fifoc <= 1'b0;
         fs_fifoc2cs  <= 1'b0;
         fd_udp_rx    <= 1'b0;
         busy         <= 1'b0;
         cmd_cnt      <= '0;
         err_cnt      <= '0;
      end else begin
         r_state      <= w_next;
         r_fifoa_q    <= fifoa_full;
         fs_mac2fifoc <= (w_next == S_MAC);
         fs_fifoc2cs  <= (w_next == S_FIFO);
         fd_udp_rx    <= (w_next == S_DONE);
         busy         <= (w_next != S_IDLE);
         if (w_next != r_state) r_tmo_cnt <= '0;
         else if (w_watched)    r_tmo_cnt <= r_tmo_cnt + 1'b1;
         if (w_cmd_inc) cmd_cnt <= cmd_cnt + 1'b1;
         err_cnt <= (w_err_sum > 9'd255) ? 8'hFF : w_err_sum[7:0];
      end
   end

endmodule

// File: doc/cs_seq.md
Name: cs_seq

Overview:
Command-path sequencer for the control-stream receive chain. It accepts a start flag from the UDP receive stage and runs the MAC-to-FIFO-C transfer followed by the FIFO-C-to-CS parse using fs/fd (flag-start/flag-done) handshakes. It then returns done to the UDP stage. FIFO full flags gate the sequence, each stage has a timeout watchdog, and completed-command and error counts are exported for LED/debug status.

Parameters:
TIMEOUT, 1024, max cycles spent in any handshake state before abort; 0 disables the watchdog
CNT_W, 16, width of completed-command counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
fifoa_full  in  1  UDP receive buffer full (overflow indicator)
fifoc_full  in  1  command FIFO C full
fifod_full  in  1  downstream FIFO D full
fs_udp_rx  in  1  UDP stage: packet ready, held high until fd_udp_rx seen
fd_udp_rx  out  1  done back to UDP stage
fs_mac2fifoc  out  1  start MAC-to-FIFO-C transfer
fd_mac2fifoc  in  1  MAC-to-FIFO-C transfer done (level)
fs_fifoc2cs  out  1  start FIFO-C-to-CS parse
fd_fifoc2cs  in  1  parse done (level)
busy  out  1  high in every state except IDLE
state  out  3  current state encoding (debug)
cmd_cnt  out  CNT_W  commands completed without error
err_cnt  out  8  saturating error count

Behaviour:
- Reset (rst=0, async): state=IDLE (0); all fs/fd outputs, busy, cmd_cnt, err_cnt and timeout counter = 0; fifoa_full edge register = 0.
- All outputs are registered (Moore). Outputs reflect the new state one clock after the transition condition is sampled.
- State encoding: IDLE=0, WAIT=1, MAC=2, FIFO=3, DONE=4, ERR=5.
- IDLE: on fs_udp_rx=1, go to WAIT if fifoc_full|fifod_full; otherwise go to MAC.
- WAIT: stay while fifoc_full|fifod_full; go to MAC on the first cycle both are low.
- MAC: fs_mac2fifoc=1. On fd_mac2fifoc=1, go to FIFO; fs_mac2fifoc drops on the same edge.
- FIFO: fs_fifoc2cs=1. On fd_fifoc2cs=1, go to DONE and increment cmd_cnt (wraps modulo 2^CNT_W).
- DONE: fd_udp_rx=1. On fs_udp_rx=0, go to IDLE; fd_udp_rx drops on the same edge. A new fs_udp_rx is never accepted in the DONE cycle.
- ERR: lasts one cycle with all fs outputs 0. It increments err_cnt, then goes to DONE. No cmd_cnt increment occurs on this path.
- Watchdog: the cycle counter clears on every state change and increments each cycle in WAIT/MAC/FIFO/DONE. When it reaches TIMEOUT-1 while the exit condition is false, the next state is ERR. A DONE timeout also goes to ERR and then back to DONE, re-arming the count. If the exit condition and the timeout occur in the same cycle, the exit condition wins.
- Overflow: each rising edge of fifoa_full (0->1, registered compare) increments err_cnt in any state.
- err_cnt saturates at 255. If an overflow edge and an ERR-state increment occur in the same cycle, add 2, clipped at 255.
- A reset asserted mid-sequence returns the block to IDLE immediately and drops all fs/fd outputs asynchronously. Counters are cleared.
- fd inputs are assumed level and held until the matching fs drops. The block does not require fd to fall before moving to the next stage.

Test Plan:
- Nominal: fs_udp_rx=1; fd_mac2fifoc pulses 3 cycles after fs_mac2fifoc rises; fd_fifoc2cs follows 5 cycles after fs_fifoc2cs rises -> state sequence 0,2,3,4,0; cmd_cnt=1; err_cnt=0; fd_udp_rx high until fs_udp_rx drops.
- Backpressure: fifoc_full=1 when fs_udp_rx rises, released after 10 cycles -> state=1 for 10 cycles; fs_mac2fifoc rises 1 cycle after release; sequence completes with cmd_cnt=1.
- Timeout: TIMEOUT=16 and fd_mac2fifoc held 0 -> ERR reached 16 cycles after MAC entry; err_cnt=1; fd_udp_rx=1; cmd_cnt=0.
- Overflow saturation: toggle fifoa_full 300 times -> err_cnt=255 and holds. Forcing simultaneous overflow edge and ERR at err_cnt=254 -> 255.
- Reset mid-op: deassert rst while in FIFO with fs_fifoc2cs=1 -> fs_fifoc2cs=0 without a clock edge; after release state=0; cmd_cnt=0.
- Back-to-back: 65536 nominal commands with CNT_W=16 -> cmd_cnt wraps to 0; no fs_udp_rx accepted in the same cycle as a DONE exit.
